sar_seq: RTL and testbench

Synchronous SAR conversion sequencer that drives the CDAC switch controller and the dynamic comparator. It generates the sample/hold phase (CKSB), the comparator clock (CLKC) and the one-hot per-bit latch strobes (CF[7:0]), MSB first. It also assembles the comparator decisions into a parallel result with a start/busy/done handshake. It sits between the digital top (tt_um wrapper) and the analog CDAC/comparator macro.

---
 rtl/sar_pkg.sv | 24 ++
 rtl/sar_timer.sv | 40 ++++
 rtl/sar_seq.sv | 206 ++++++++++++++++++++
 tb/tb_sar_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// +--------------------------------------------------------------------+
// | sar_pkg: shared types and defaults for the SAR sequencer           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_EVAL   = 3'd2,
    S_LATCH  = 3'd3,
    S_PRE    = 3'd4,
    S_FIN    = 3'd5
  } sar_state_t;

  localparam int SAR_NBITS      = 8;
  localparam int SAR_SAMPLE_CYC = 2;
  localparam int SAR_CMP_WAIT   = 1;

endpackage

`default_nettype wire

// File: rtl/sar_timer.sv
// +--------------------------------------------------------------------+
// | sar_timer: loadable 4-bit down-counter with zero flag              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sar_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/sar_seq.sv
// +--------------------------------------------------------------------+
// | sar_seq: SAR conversion sequencer (CKSB / CLKC / CF strobes,       |
// |          result assembly, start/busy/done handshake).              |
// | Optional: SAR_META_DET_EN enables comparator metastability flag.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sar_seq
  import sar_pkg::*;
#(
  parameter int NBITS      = SAR_NBITS,
  parameter int SAMPLE_CYC = SAR_SAMPLE_CYC,
  parameter int CMP_WAIT   = SAR_CMP_WAIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             START,
  input  logic             CMP_P,
  input  logic             CMP_N,
  output logic             CKSB,
  output logic             CLKC,
  output logic [NBITS-1:0] CF,
  output logic             BUSY,
  output logic             DONE,
  output logic [NBITS-1:0] DATA,
  output logic             ERR
);

  localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NBITS - 1);
  localparam logic [3:0] SAMPLE_LD = 4'(SAMPLE_CYC - 1);
  localparam logic [3:0] CMP_LD    = 4'(CMP_WAIT - 1);

  sar_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NBITS-1:0] work_q, work_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             flag_q, flag_d;
  logic             cksb_q, cksb_d;
  logic             clkc_q, clkc_d;
  logic [NBITS-1:0] cf_q, cf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tmr_load, tmr_en, tmr_zero;
  logic [3:0]       tmr_val;

  sar_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State and datapath register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_MSB;
      work_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
      cksb_q  <= 1'b0;
      clkc_q  <= 1'b0;
      cf_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      data_q  <= data_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      cksb_q  <= cksb_d;
      clkc_q  <= clkc_d;
      cf_q    <= cf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    work_d   = work_q;
    data_d   = data_q;
    err_d    = err_q;
    flag_d   = flag_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = CMP_LD;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_SAMPLE;
          idx_d    = IDX_MSB;
          work_d   = '0;
          flag_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = SAMPLE_LD;
        end
      end
      S_SAMPLE: begin
        if (tmr_zero) begin
          state_d  = S_EVAL;
          tmr_load = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_EVAL: begin
        if (tmr_zero) begin
          state_d = S_LATCH;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_LATCH: begin
        work_d[idx_q] = CMP_P;
`ifdef SAR_META_DET_EN
        if (CMP_P == CMP_N) begin
          flag_d = 1'b1;
        end
`endif
        if (idx_q == '0) begin
          state_d = S_FIN;
          data_d  = work_d;
          err_d   = flag_d;
        end else begin
          state_d = S_PRE;
          idx_d   = idx_q - 1'b1;
        end
      end
      S_PRE: begin
        state_d  = S_EVAL;
        tmr_load = 1'b1;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so that they are registered
  always_comb begin
    cksb_d = 1'b0;
    clkc_d = 1'b0;
    cf_d   = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_SAMPLE: begin
        busy_d = 1'b1;
      end
      S_EVAL: begin
        cksb_d = 1'b1;
        clkc_d = 1'b1;
        busy_d = 1'b1;
      end
      S_LATCH: begin
        cksb_d = 1'b1;
        clkc_d = 1'b1;
        busy_d = 1'b1;
        cf_d   = NBITS'(1) << idx_d;
      end
      S_PRE: begin
        cksb_d = 1'b1;
        busy_d = 1'b1;
      end
      S_FIN: begin
        cksb_d = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        cksb_d = 1'b0;
      end
    endcase
  end

`ifndef SAR_META_DET_EN
  logic unused_cmp_n;
  assign unused_cmp_n = CMP_N;
`endif

  assign CKSB = cksb_q;
  assign CLKC = clkc_q;
  assign CF   = cf_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign DATA = data_q;
  assign ERR  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sar_seq.sv
// +--------------------------------------------------------------------+
// | tb_sar_seq: directed scoreboard bench for sar_seq                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sar_seq;
  import sar_pkg::*;

  localparam int NB = 8;
`ifdef SAR_META_DET_EN
  localparam logic META_ERR = 1'b1;
`else
  localparam logic META_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic [NB-1:0] code_r = '0;
  logic meta_on = 1'b0;
  logic sel = 1'b0;

  logic cksb_a, clkc_a, busy_a, done_a, err_a, cmp_p_a, cmp_n_a, hit_a;
  logic cksb_b, clkc_b, busy_b, done_b, err_b, cmp_p_b, cmp_n_b, hit_b;
  logic [NB-1:0] cf_a, data_a, cf_b, data_b;

  always #5 clk = ~clk;

  // Comparator models: decision is the code bit addressed by the strobe
  assign hit_a   = meta_on && cf_a[4];
  assign cmp_p_a = hit_a ? 1'b1 : |(cf_a & code_r);
  assign cmp_n_a = hit_a ? 1'b1 : ~(|(cf_a & code_r));
  assign hit_b   = meta_on && cf_b[4];
  assign cmp_p_b = hit_b ? 1'b1 : |(cf_b & code_r);
  assign cmp_n_b = hit_b ? 1'b1 : ~(|(cf_b & code_r));

  sar_seq dut_a (
    .clk(clk), .rst_n(rst_n), .START(start_a), .CMP_P(cmp_p_a), .CMP_N(cmp_n_a),
    .CKSB(cksb_a), .CLKC(clkc_a), .CF(cf_a), .BUSY(busy_a), .DONE(done_a),
    .DATA(data_a), .ERR(err_a)
  );

  sar_seq #(.NBITS(NB), .SAMPLE_CYC(4), .CMP_WAIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .START(start_b), .CMP_P(cmp_p_b), .CMP_N(cmp_n_b),
    .CKSB(cksb_b), .CLKC(clkc_b), .CF(cf_b), .BUSY(busy_b), .DONE(done_b),
    .DATA(data_b), .ERR(err_b)
  );

  logic m_cksb, m_clkc, m_busy, m_done, m_err;
  logic [NB-1:0] m_cf, m_data;
  assign m_cksb = sel ? cksb_b : cksb_a;
  assign m_clkc = sel ? clkc_b : clkc_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_err  = sel ? err_b  : err_a;
  assign m_cf   = sel ? cf_b   : cf_a;
  assign m_data = sel ? data_b : data_a;

  int vectors = 0;
  int errors  = 0;
  logic [NB-1:0] sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on conversion cycle 1; returns the cycle index of DONE
  task automatic run_until_done(input int sc, input int cw, output int lat);
    int idx = NB - 1;
    int hi = 0;
    lat = 1;
    while (!m_done && lat < 300) begin
      if (m_cf != '0) begin
        chk("cf_strobe", 32'(m_cf), (idx >= 0) ? (32'd1 << idx) : 32'd0);
        chk("cf_time", 32'(lat), 32'(sc + (NB - 1 - idx) * (cw + 2) + cw + 1));
        chk("cf_gated", 32'(m_cksb & m_clkc), 32'd1);
        idx--;
      end
      if (m_clkc) hi++;
      tick();
      lat++;
    end
    chk("done_seen", 32'(m_done), 32'd1);
    chk("cf_count", 32'(idx), 32'hFFFF_FFFF);
    chk("clkc_hi", 32'(hi), 32'(NB * (cw + 1)));
  endtask

  task automatic pop_check(input logic exp_err);
    logic [NB-1:0] exp;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      chk("data", 32'(m_data), 32'(exp));
      chk("err", 32'(m_err), 32'(exp_err));
    end
  endtask

  task automatic convert(input logic [NB-1:0] code, input logic meta, input logic exp_err,
                         input int sc, input int cw);
    int lat;
    code_r  = code;
    meta_on = meta;
    sb.push_back(meta ? (code | 8'h10) : code);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    chk("busy_rise", 32'(m_busy), 32'd1);
    chk("sample_cksb", 32'(m_cksb), 32'd0);
    run_until_done(sc, cw, lat);
    chk("done_lat", 32'(lat), 32'(sc + NB * (cw + 2)));
    pop_check(exp_err);
    meta_on = 1'b0;
    tick();
    chk("done_pulse", 32'(m_done), 32'd0);
    chk("idle_busy", 32'(m_busy), 32'd0);
    chk("idle_cksb", 32'(m_cksb), 32'd0);
  endtask

  initial begin : main
    int lat;
    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_cksb", 32'(cksb_a), 32'd0);
    chk("rst_clkc", 32'(clkc_a), 32'd0);
    chk("rst_cf", 32'(cf_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_state", 32'(dut_a.state_q), 32'(S_IDLE));

    // Default conversion, metastability case, clean follow-up
    sel = 1'b0;
    convert(8'hA5, 1'b0, 1'b0, 2, 1);
    convert(8'hA5, 1'b1, META_ERR, 2, 1);
    convert(8'h5A, 1'b0, 1'b0, 2, 1);

    // Back-to-back with START held high
    code_r = 8'h00;
    sb.push_back(8'h00);
    start_a = 1'b1;
    tick();
    run_until_done(2, 1, lat);
    chk("b2b_lat1", 32'(lat), 32'd26);
    pop_check(1'b0);
    code_r = 8'hFF;
    sb.push_back(8'hFF);
    tick();
    chk("b2b_idle", 32'(busy_a), 32'd0);
    tick();
    chk("b2b_restart", 32'(busy_a), 32'd1);
    run_until_done(2, 1, lat);
    chk("b2b_spacing", 32'(lat + 1), 32'd27);
    pop_check(1'b0);
    start_a = 1'b0;
    tick();
    tick();
    chk("no_requeue", 32'(busy_a), 32'd0);

    // Mid-conversion reset at cycle 12
    code_r = 8'h99;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (11) tick();
    chk("pre_rst_cksb", 32'(cksb_a), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mrst_cksb", 32'(cksb_a), 32'd0);
    chk("mrst_cf", 32'(cf_a), 32'd0);
    chk("mrst_busy", 32'(busy_a), 32'd0);
    chk("mrst_data", 32'(data_a), 32'd0);
    chk("mrst_clkc", 32'(clkc_a), 32'd0);
    rst_n = 1'b1;
    tick();
    convert(8'h3C, 1'b0, 1'b0, 2, 1);

    // Parameter sweep instance
    sel = 1'b1;
    convert(8'hC3, 1'b0, 1'b0, 4, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
